tdm_demux: RTL and testbench

Receive end of the team's time-division multiplexed serial link. It takes a one-bit serial stream with a frame-sync marker, locks to frame boundaries, and deserializes each frame of `CHANNELS` slots × `WIDTH` bits into a parallel word. Each completed frame is presented downstream on a valid/ready handshake. The block also reports loss of sync and overrun.

---
 rtl/tdm_pkg.sv | 19 +
 rtl/tdm_bit_counter.sv | 38 +++
 rtl/tdm_demux.sv | 156 +++++++++++++++
 tb/tb_tdm_demux.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared TDM link definitions: FSM state encoding and frame geometry helpers.
// Used by both the receive demux and the transmit-side mux.
package tdm_pkg;

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_RECV = 1'b1
    } tdm_state_e;

    function automatic int tdm_frame_bits(input int channels, input int width);
        return channels * width;
    endfunction

    // A one-bit frame still needs a one-bit counter.
    function automatic int tdm_cnt_w(input int channels, input int width);
        return (channels * width > 1) ? $clog2(channels * width) : 1;
    endfunction

endpackage

// File: rtl/tdm_bit_counter.sv
// Modulo-FRAME_BITS bit position counter; clear beats load-to-1, which beats increment.
// Outputs are registered count plus combinational zero/last decodes; never stalls.
module tdm_bit_counter #(
    parameter int FRAME_BITS = 32,
    parameter int CW         = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_en,
    input  logic          i_load1,
    input  logic          i_clr,
    output logic [CW-1:0] o_count,
    output logic          o_is_zero,
    output logic          o_is_last
);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load1) begin
            r_count <= CW'(1);
        end else if (i_en) begin
            if (r_count == CW'(FRAME_BITS - 1))
                r_count <= '0;
            else
                r_count <= r_count + CW'(1);
        end
    end

    assign o_count   = r_count;
    assign o_is_zero = (r_count == '0);
    assign o_is_last = (r_count == CW'(FRAME_BITS - 1));

endmodule

// File: rtl/tdm_demux.sv
// TDM receiver: locks on sync, deserializes CHANNELS*WIDTH bits, frame_valid one cycle after last bit.
// A frame completing while the previous one is still held and not accepted is dropped with an overrun pulse.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         bit_in,
    input  logic                         bit_en,
    input  logic                         sync,
    output logic [CHANNELS*WIDTH-1:0]    frame_data,
    output logic                         frame_valid,
    input  logic                         frame_ready,
    output logic                         locked,
    output logic                         sync_err,
    output logic                         overrun
);

    localparam int FB = tdm_frame_bits(CHANNELS, WIDTH);
    localparam int CW = tdm_cnt_w(CHANNELS, WIDTH);

    tdm_state_e     r_state;
    logic [FB-2:0]  r_shift;
    logic [FB-1:0]  r_data;
    logic           r_valid;
    logic           r_locked;
    logic           r_sync_err;
    logic           r_overrun;

    logic [CW-1:0]  w_count;
    logic           w_is_zero;
    logic           w_is_last;
    logic           w_cnt_en;
    logic           w_cnt_load1;
    logic           w_cnt_clr;
    logic           w_shift_en;
    logic           w_done;
    logic [FB-1:0]  w_frame;

    tdm_bit_counter #(
        .FRAME_BITS (FB),
        .CW         (CW)
    ) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (w_cnt_en),
        .i_load1   (w_cnt_load1),
        .i_clr     (w_cnt_clr),
        .o_count   (w_count),
        .o_is_zero (w_is_zero),
        .o_is_last (w_is_last)
    );

    always_comb begin
        assert (w_is_zero == (w_count == '0));
    end

    // Whole-frame left shift puts channel 0 in the top field.
    assign w_frame = {r_shift, bit_in};

    always_comb begin
        w_cnt_en    = 1'b0;
        w_cnt_load1 = 1'b0;
        w_cnt_clr   = 1'b0;
        w_shift_en  = 1'b0;
        w_done      = 1'b0;
        if (bit_en) begin
            case (r_state)
                ST_HUNT: begin
                    if (sync) begin
                        w_cnt_load1 = 1'b1;
                        w_shift_en  = 1'b1;
                    end
                end
                ST_RECV: begin
                    if (w_is_zero) begin
                        if (sync) begin
                            w_cnt_en   = 1'b1;
                            w_shift_en = 1'b1;
                        end else begin
                            w_cnt_clr  = 1'b1;
                        end
                    end else if (sync) begin
                        w_cnt_load1 = 1'b1;
                        w_shift_en  = 1'b1;
                    end else begin
                        w_cnt_en   = 1'b1;
                        w_shift_en = 1'b1;
                        w_done     = w_is_last;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_HUNT;
            r_locked   <= 1'b0;
            r_sync_err <= 1'b0;
            r_overrun  <= 1'b0;
            r_shift    <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_sync_err <= 1'b0;
            r_overrun  <= 1'b0;

            if (bit_en) begin
                case (r_state)
                    ST_HUNT: begin
                        if (sync) begin
                            r_state  <= ST_RECV;
                            r_locked <= 1'b1;
                        end
                    end
                    ST_RECV: begin
                        if (w_is_zero && !sync) begin
                            r_state    <= ST_HUNT;
                            r_locked   <= 1'b0;
                            r_sync_err <= 1'b1;
                        end else if (!w_is_zero && sync) begin
                            r_sync_err <= 1'b1;
                        end
                    end
                    default: r_state <= ST_HUNT;
                endcase
            end

            if (w_shift_en)
                r_shift <= w_frame[FB-2:0];

            if (w_done) begin
                if (!r_valid || frame_ready) begin
                    r_data  <= w_frame;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && frame_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign frame_data  = r_data;
    assign frame_valid = r_valid;
    assign locked      = r_locked;
    assign sync_err    = r_sync_err;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: directed scenarios plus random traffic against a bit-queue reference model.
module tb_tdm_demux;

    localparam int CH = 4;
    localparam int W  = 8;
    localparam int FB = CH * W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          bit_in = 1'b0;
    logic          bit_en = 1'b0;
    logic          sync = 1'b0;
    logic          frame_ready = 1'b0;
    logic [FB-1:0] frame_data;
    logic          frame_valid;
    logic          locked;
    logic          sync_err;
    logic          overrun;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tdm_demux #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bit_in      (bit_in),
        .bit_en      (bit_en),
        .sync        (sync),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .locked      (locked),
        .sync_err    (sync_err),
        .overrun     (overrun)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Reference model: collected bits of the current frame, held-frame flag, expected frames.
    bit            m_locked = 1'b0;
    bit            m_valid  = 1'b0;
    bit            m_serr   = 1'b0;
    bit            m_ovr    = 1'b0;
    bit            bits[$];
    logic [FB-1:0] exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_locked = 1'b0;
            m_valid  = 1'b0;
            m_serr   = 1'b0;
            m_ovr    = 1'b0;
            bits.delete();
            exp_q.delete();
        end else begin
            bit            xfer;
            bit            done;
            logic [FB-1:0] word;
            xfer   = m_valid && frame_ready;
            done   = 1'b0;
            word   = '0;
            m_serr = 1'b0;
            m_ovr  = 1'b0;
            if (bit_en) begin
                if (!m_locked) begin
                    if (sync) begin
                        bits.delete();
                        bits.push_back(bit_in);
                        m_locked = 1'b1;
                    end
                end else if (bits.size() == 0) begin
                    if (sync) bits.push_back(bit_in);
                    else begin
                        m_serr   = 1'b1;
                        m_locked = 1'b0;
                    end
                end else if (sync) begin
                    m_serr = 1'b1;
                    bits.delete();
                    bits.push_back(bit_in);
                end else begin
                    bits.push_back(bit_in);
                    if (bits.size() == FB) begin
                        for (int i = 0; i < FB; i++) word[FB-1-i] = bits[i];
                        bits.delete();
                        done = 1'b1;
                    end
                end
            end
            if (done) begin
                if (!m_valid || xfer) begin
                    exp_q.push_back(word);
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (xfer) begin
                m_valid = 1'b0;
            end
        end
    end

    int            n_serr_seen = 0;
    int            n_ovr_seen  = 0;
    int            n_xfer      = 0;
    logic [FB-1:0] last_xfer   = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("locked", locked, m_locked);
            chk("sync_err", sync_err, m_serr);
            chk("overrun", overrun, m_ovr);
            chk("frame_valid", frame_valid, m_valid);
            if (sync_err) n_serr_seen++;
            if (overrun)  n_ovr_seen++;
            if (frame_valid && frame_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL xfer: got frame %h required no frame", frame_data);
                end else begin
                    chk("frame_data", frame_data, exp_q.pop_front());
                end
                n_xfer++;
                last_xfer = frame_data;
            end
        end
    end

    task automatic drive(input logic b, input logic s, input logic en, input logic rdy);
        bit_in      = b;
        sync        = s;
        bit_en      = en;
        frame_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [FB-1:0] w, input logic rdy, input bit gap, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            drive(w[FB-1-i], i == 0, 1'b1, rdy);
            if (gap) drive(1'b0, 1'b1, 1'b0, rdy);
        end
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, rdy);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data"}, frame_data, 32'h0);
        chk({tag, "_valid"}, frame_valid, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_serr"}, sync_err, 0);
        chk({tag, "_ovr"}, overrun, 0);
    endtask

    initial begin
        int s0;
        int o0;
        int x0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        idle(2, 1'b1);

        // Basic frame
        send(32'hA1B2C3D4, 1'b1, 1'b0, FB);
        idle(3, 1'b1);
        chk("basic_data", last_xfer, 32'hA1B2C3D4);

        // Overrun: second frame dropped while first is held
        o0 = n_ovr_seen;
        send(32'h11223344, 1'b0, 1'b0, FB);
        send(32'h55667788, 1'b0, 1'b0, FB);
        idle(2, 1'b0);
        chk("ovr_pulses", n_ovr_seen - o0, 1);
        chk("ovr_hold_data", frame_data, 32'h11223344);
        chk("ovr_hold_valid", frame_valid, 1);
        idle(2, 1'b1);
        chk("ovr_drained", frame_valid, 0);
        chk("ovr_xfer_data", last_xfer, 32'h11223344);

        // Early sync at counter 10
        s0 = n_serr_seen;
        send(32'h12345678, 1'b1, 1'b0, 10);
        send(32'hDEADBEEF, 1'b1, 1'b0, FB);
        idle(3, 1'b1);
        chk("early_serr", n_serr_seen - s0, 1);
        chk("early_locked", locked, 1);
        chk("early_data", last_xfer, 32'hDEADBEEF);

        // Lost sync
        send(32'h13572468, 1'b1, 1'b0, FB);
        idle(2, 1'b1);
        s0 = n_serr_seen;
        x0 = n_xfer;
        for (int i = 0; i < 40; i++) drive(1'($urandom), 1'b0, 1'b1, 1'b1);
        chk("lost_serr", n_serr_seen - s0, 1);
        chk("lost_locked", locked, 0);
        chk("lost_noframe", n_xfer - x0, 0);

        // Gapped input
        send(32'h0F0F00FF, 1'b1, 1'b1, FB);
        idle(3, 1'b1);
        chk("gap_data", last_xfer, 32'h0F0F00FF);

        // Reset mid-frame
        send(32'h24681357, 1'b1, 1'b0, 16);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(32'hCAFEF00D, 1'b1, 1'b0, FB);
        idle(3, 1'b1);
        chk("postrst_data", last_xfer, 32'hCAFEF00D);

        // Random traffic: gaps, random ready, occasional early or missing sync
        for (int f = 0; f < 40; f++) begin
            logic [FB-1:0] w;
            int            mode;
            int            nb;
            w    = $urandom;
            mode = $urandom_range(0, 9);
            nb   = (mode == 0) ? $urandom_range(1, FB - 1) : FB;
            for (int i = 0; i < nb; i++) begin
                while ($urandom_range(0, 3) == 0)
                    drive(1'($urandom), 1'($urandom), 1'b0, $urandom_range(0, 9) < 7);
                drive(w[FB-1-i], (i == 0) && (mode != 1), 1'b1, $urandom_range(0, 9) < 7);
            end
        end
        idle(6, 1'b1);
        chk("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
